wt_dcache_flush_ctrl: RTL and testbench
=======================================

Name: wt_dcache_flush_ctrl

Overview:
- Sequencer that invalidates L1 write-through dcache lines through the full-cacheline tag/valid write port of the dcache memory array.
- Supports two operations: a whole-cache flush that walks every set and clears all ways, and a single-line invalidate of selected ways in one set.
- Sits between the fence/CSR logic (requesters) and the dcache miss/refill port-0 arbiter (shared resource). It drains the write buffer before a flush and holds the cache busy while working.

Parameters:
- NumSets, 256, number of cache sets; must be a power of two, ≥ 2.
- IdxWidth, $clog2(NumSets), set-index width.
- SetAssoc, 4, number of ways.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_req_i  in  1  full-flush request; level, held until flush_ack_o.
- flush_ack_o  out  1  one-cycle pulse: flush complete.
- inv_req_i  in  1  single-line invalidate request; level, held until inv_ack_o.
- inv_idx_i  in  IdxWidth  set to invalidate; sampled on acceptance.
- inv_way_i  in  SetAssoc  way mask to invalidate; sampled on acceptance.
- inv_ack_o  out  1  one-cycle pulse: invalidate done.
- wbuffer_empty_i  in  1  write buffer holds no pending entries.
- busy_o  out  1  controller active; the cache stalls new loads and stores.
- mem_req_o  out  1  request for the port-0 cacheline write slot.
- mem_gnt_i  in  1  slot granted this cycle; combinational from mem_req_o is allowed.
- wr_cl_vld_o  out  1  cacheline write strobe, equal to mem_req_o & mem_gnt_i.
- wr_cl_we_o  out  SetAssoc  way write enables.
- wr_cl_idx_o  out  IdxWidth  set index being written.
- wr_vld_bits_o  out  SetAssoc  valid bits to write; constant 0.
- wr_cl_nc_o  out  1  constant 0.

Behaviour:
- States:
  - IDLE: no operation.
  - DRAIN: waiting for the write buffer to empty.
  - FLUSH: walking all sets.
  - INV: invalidating one line.
  - DONE: signalling flush completion.
- Reset (async, rst_i=1):
  - state goes to IDLE; index counter, latched idx and latched way go to 0.
  - All outputs are 0. wr_vld_bits_o is always 0.
- IDLE:
  - flush_req_i=1 → DRAIN. flush wins if flush_req_i and inv_req_i are both high.
  - Otherwise inv_req_i=1 with inv_way_i≠0 → latch idx and way, go to INV.
  - inv_req_i=1 with inv_way_i=0 → pulse inv_ack_o in the next cycle with no memory access; stay IDLE.
- DRAIN: wbuffer_empty_i=1 → FLUSH with counter=0. Otherwise stay in DRAIN; there is no timeout.
- FLUSH:
  - mem_req_o=1, wr_cl_we_o='1, wr_cl_idx_o=counter.
  - On mem_gnt_i the counter increments. When the counter equals NumSets-1 and is granted → DONE.
  - With no grant, the counter and outputs hold.
- DONE: flush_ack_o=1 for one cycle → IDLE. The counter wraps to 0.
- INV:
  - mem_req_o=1, wr_cl_we_o=latched way, wr_cl_idx_o=latched idx.
  - On mem_gnt_i → inv_ack_o=1 in the next cycle, then IDLE.
- Outputs when mem_req_o=0: wr_cl_we_o=0 and wr_cl_idx_o=0.
- busy_o = 1 in every state except IDLE.
- Latency with constant grant and an empty write buffer:
  - flush: request seen at cycle 0; DRAIN at cycle 1; FLUSH at cycles 2..NumSets+1; flush_ack_o at cycle NumSets+2.
  - invalidate: request seen at cycle 0; INV write at cycle 1; inv_ack_o at cycle 2.
- Requests arriving while busy are ignored until the state returns to IDLE. An inv_req_i held during a flush is served afterwards.
- A requester dropping its request mid-operation does not abort it; the ack still pulses once.
- Reset mid-flush: the flush is abandoned and no ack is produced. Cache contents are undefined; the requester must re-issue.
- Each ack pulses exactly once per accepted request. The controller never issues wr_cl_vld_o while in DRAIN.

Test Plan:
- Flush, NumSets=256, grant=1, wbuffer_empty_i=1 → wr_cl_vld_o high cycles 2..257 with idx 0..255 and we=4'b1111; flush_ack_o at cycle 258; busy_o high at cycles 1..258.
- Flush with wbuffer_empty_i=0 for 10 cycles → no wr_cl_vld_o until empty; idx sequence is unchanged; ack is delayed by 10 cycles.
- Random 50% mem_gnt_i during flush → every index 0..255 written exactly once, in order; one flush_ack_o.
- inv_req_i with idx=0x3A, way=4'b0100 → one write at idx 0x3A, we=0100, vld_bits=0; inv_ack_o at cycle 2; busy_o at cycle 1 only.
- flush_req_i and inv_req_i asserted together → flush completes first; then the inv write and inv_ack_o follow; inv_way_i=0 → inv_ack_o with no write.
- rst_i asserted at flush index 100 → all outputs 0 immediately; state IDLE; a new flush restarts at index 0.

Source files
------------

// File: rtl/wt_dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// wt_dcache_flush_ctrl
//
// Purpose:
//   Invalidation sequencer for the L1 write-through dcache. It clears
//   tag/valid entries through the full-cacheline write port of the dcache
//   memory array. Two operations are supported:
//     - whole-cache flush: drain the write buffer, then walk every set and
//       clear all ways, then pulse flush_ack_o.
//     - single-line invalidate: clear the selected ways of one set, then
//       pulse inv_ack_o.
//   While an operation is in progress busy_o stalls new loads and stores.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_req_i/flush_ack_o full-flush request (level) / completion pulse
//   inv_req_i/inv_ack_o     invalidate request (level) / completion pulse
//   inv_idx_i, inv_way_i    set index and way mask, sampled on acceptance
//   wbuffer_empty_i         write buffer has no pending entries
//   busy_o                  controller is active
//   mem_req_o/mem_gnt_i     request/grant for the port-0 cacheline slot
//   wr_cl_*_o, wr_vld_bits_o cacheline write port towards the memory array
// ---------------------------------------------------------------------------
module wt_dcache_flush_ctrl #(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned IdxWidth = $clog2(NumSets),
    parameter int unsigned SetAssoc = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    input  logic                inv_req_i,
    input  logic [IdxWidth-1:0] inv_idx_i,
    input  logic [SetAssoc-1:0] inv_way_i,
    output logic                inv_ack_o,
    input  logic                wbuffer_empty_i,
    output logic                busy_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                wr_cl_vld_o,
    output logic [SetAssoc-1:0] wr_cl_we_o,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [SetAssoc-1:0] wr_vld_bits_o,
    output logic                wr_cl_nc_o
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StDrain = 3'd1;
    localparam logic [2:0] StFlush = 3'd2;
    localparam logic [2:0] StInv   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    logic [2:0]          r_state;
    logic [IdxWidth-1:0] r_cnt;
    logic [IdxWidth-1:0] r_inv_idx;
    logic [SetAssoc-1:0] r_inv_way;
    logic                r_inv_ack;

    logic [2:0]          w_next_state;
    logic [IdxWidth-1:0] w_cnt_next;
    logic                w_accept_inv;
    logic                w_inv_ack_next;

    // Next-state logic. Flush has priority over invalidate in IDLE. An
    // invalidate request is not re-accepted during the cycle its ack is
    // pulsing, because the requester is still holding the level request in
    // that cycle; accepting it again would produce a second ack.
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_accept_inv   = 1'b0;
        w_inv_ack_next = 1'b0;
        case (r_state)
            StIdle: begin
                if (flush_req_i) begin
                    w_next_state = StDrain;
                end else if (inv_req_i && !r_inv_ack) begin
                    if (|inv_way_i) begin
                        w_accept_inv = 1'b1;
                        w_next_state = StInv;
                    end else begin
                        // Empty way mask: nothing to write, acknowledge directly.
                        w_inv_ack_next = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (wbuffer_empty_i) begin
                    w_next_state = StFlush;
                    w_cnt_next   = '0;
                end
            end
            StFlush: begin
                if (mem_gnt_i) begin
                    // The counter wraps back to 0 naturally after the last set.
                    w_cnt_next = r_cnt + IdxWidth'(1);
                    if (r_cnt == LastIdx) begin
                        w_next_state = StDone;
                    end
                end
            end
            StInv: begin
                if (mem_gnt_i) begin
                    w_next_state   = StIdle;
                    w_inv_ack_next = 1'b1;
                end
            end
            StDone: begin
                w_next_state = StIdle;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    // State, set counter, latched invalidate target and the registered
    // invalidate acknowledge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_inv_idx <= '0;
            r_inv_way <= '0;
            r_inv_ack <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_inv_ack <= w_inv_ack_next;
            if (w_accept_inv) begin
                r_inv_idx <= inv_idx_i;
                r_inv_way <= inv_way_i;
            end
        end
    end

    // Write-port outputs are forced to zero whenever no slot is requested so
    // the arbiter never sees stale index/enable values.
    always_comb begin
        mem_req_o   = (r_state == StFlush) || (r_state == StInv);
        wr_cl_we_o  = '0;
        wr_cl_idx_o = '0;
        if (r_state == StFlush) begin
            wr_cl_we_o  = '1;
            wr_cl_idx_o = r_cnt;
        end else if (r_state == StInv) begin
            wr_cl_we_o  = r_inv_way;
            wr_cl_idx_o = r_inv_idx;
        end
    end

    assign wr_cl_vld_o   = mem_req_o & mem_gnt_i;
    assign wr_vld_bits_o = '0;
    assign wr_cl_nc_o    = 1'b0;
    assign flush_ack_o   = (r_state == StDone);
    assign inv_ack_o     = r_inv_ack;
    assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_wt_dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wt_dcache_flush_ctrl
//
// Directed testbench for wt_dcache_flush_ctrl (NumSets=256, SetAssoc=4).
// Inputs are driven on the falling clock edge and outputs are sampled 1 time
// unit later, well away from the rising edge. "Cycle c" of a scenario is the
// clock period in which the request is first presented (c=0) plus c.
// ---------------------------------------------------------------------------
module tb_wt_dcache_flush_ctrl;

    logic       clk;
    logic       rst;
    logic       flushReq;
    logic       flushAck;
    logic       invReq;
    logic [7:0] invIdx;
    logic [3:0] invWay;
    logic       invAck;
    logic       wbEmpty;
    logic       busy;
    logic       memReq;
    logic       memGnt;
    logic       clVld;
    logic [3:0] clWe;
    logic [7:0] clIdx;
    logic [3:0] vldBits;
    logic       clNc;

    int checkCount = 0;
    int errorCount = 0;

    // Packed view of all outputs: {flushAck, invAck, busy, memReq, clVld,
    // clWe, clIdx, vldBits, clNc}
    logic [21:0] obs;
    assign obs = {flushAck, invAck, busy, memReq, clVld, clWe, clIdx, vldBits, clNc};

    wt_dcache_flush_ctrl #(
        .NumSets  (256),
        .SetAssoc (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_req_i     (flushReq),
        .flush_ack_o     (flushAck),
        .inv_req_i       (invReq),
        .inv_idx_i       (invIdx),
        .inv_way_i       (invWay),
        .inv_ack_o       (invAck),
        .wbuffer_empty_i (wbEmpty),
        .busy_o          (busy),
        .mem_req_o       (memReq),
        .mem_gnt_i       (memGnt),
        .wr_cl_vld_o     (clVld),
        .wr_cl_we_o      (clWe),
        .wr_cl_idx_o     (clIdx),
        .wr_vld_bits_o   (vldBits),
        .wr_cl_nc_o      (clNc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an expected output vector; valid bits and nc are always zero.
    function automatic logic [21:0] expVec(input logic fa, input logic ia, input logic bz,
                                           input logic rq, input logic vl,
                                           input logic [3:0] we, input logic [7:0] idx);
        return {fa, ia, bz, rq, vl, we, idx, 4'b0000, 1'b0};
    endfunction

    // Reset must force every output to zero asynchronously.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCount++;
        if (obs !== 22'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 22'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkCount++;
        if (obs !== 22'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, 22'h0);
        end
    endtask

    // Full flush with constant grant; the write buffer stays non-empty for
    // 'drain' cycles after the request, delaying everything by 'drain'.
    task automatic test_flush(input int drain);
        logic [21:0] exp;
        logic        inFl;
        @(negedge clk);
        flushReq = 1'b1;
        memGnt   = 1'b1;
        for (int c = 0; c <= 259 + drain; c++) begin
            wbEmpty = (c >= 1 + drain);
            #1;
            inFl = (c >= 2 + drain) && (c <= 257 + drain);
            exp  = expVec(c == 258 + drain, 1'b0, (c >= 1) && (c <= 258 + drain),
                          inFl, inFl, inFl ? 4'hF : 4'h0, inFl ? 8'(c - 2 - drain) : 8'h00);
            checkCount++;
            if (obs !== exp) begin
                errorCount++;
                $display("[TB] FAIL flush_d%0d cycle %0d: got %h expected %h", drain, c, obs, exp);
            end
            if (c == 258 + drain) flushReq = 1'b0;
            @(negedge clk);
        end
        wbEmpty = 1'b1;
    endtask

    // Flush under a random 50% grant: each set written exactly once in order.
    task automatic test_random_grant();
        int  nextIdx = 0;
        int  acks    = 0;
        int  extra   = 0;
        bit  done    = 0;
        @(negedge clk);
        flushReq = 1'b1;
        wbEmpty  = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            memGnt = 1'($urandom_range(0, 1));
            #1;
            if (clVld) begin
                checkCount++;
                if (clIdx !== nextIdx[7:0] || clWe !== 4'hF || nextIdx > 255) begin
                    errorCount++;
                    $display("[TB] FAIL rand_write #%0d: got idx %h we %h expected idx %h we f",
                             nextIdx, clIdx, clWe, nextIdx[7:0]);
                end
                nextIdx++;
            end
            if (flushAck) begin
                acks++;
                flushReq = 1'b0;
                done     = 1;
            end
            @(negedge clk);
        end
        memGnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (flushAck) acks++;
            if (clVld) extra++;
            @(negedge clk);
        end
        checkCount++;
        if (nextIdx != 256 || extra != 0) begin
            errorCount++;
            $display("[TB] FAIL rand_write_count: got %0d (+%0d late) expected 256", nextIdx, extra);
        end
        checkCount++;
        if (acks != 1) begin
            errorCount++;
            $display("[TB] FAIL rand_ack_count: got %0d expected 1", acks);
        end
    endtask

    // Single-line invalidate; inputs change after acceptance to prove latching.
    task automatic test_invalidate();
        logic [21:0] exp;
        @(negedge clk);
        memGnt = 1'b1;
        invReq = 1'b1;
        invIdx = 8'h3A;
        invWay = 4'b0100;
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) begin
                invIdx = 8'h55;
                invWay = 4'b1001;
            end
            #1;
            exp = expVec(1'b0, c == 2, c == 1, c == 1, c == 1,
                         (c == 1) ? 4'b0100 : 4'b0000, (c == 1) ? 8'h3A : 8'h00);
            checkCount++;
            if (obs !== exp) begin
                errorCount++;
                $display("[TB] FAIL inv cycle %0d: got %h expected %h", c, obs, exp);
            end
            if (c == 2) invReq = 1'b0;
            @(negedge clk);
        end
    endtask

    // Simultaneous requests: flush first, then the held invalidate.
    task automatic test_flush_and_inv();
        logic [21:0] exp;
        logic        inFl;
        @(negedge clk);
        memGnt   = 1'b1;
        wbEmpty  = 1'b1;
        flushReq = 1'b1;
        invReq   = 1'b1;
        invIdx   = 8'h12;
        invWay   = 4'b0011;
        for (int c = 0; c <= 262; c++) begin
            #1;
            inFl = (c >= 2) && (c <= 257);
            if (c == 260)
                exp = expVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 8'h12);
            else
                exp = expVec(c == 258, c == 261, (c >= 1) && (c <= 258),
                             inFl, inFl, inFl ? 4'hF : 4'h0, inFl ? 8'(c - 2) : 8'h00);
            checkCount++;
            if (obs !== exp) begin
                errorCount++;
                $display("[TB] FAIL flush_inv cycle %0d: got %h expected %h", c, obs, exp);
            end
            if (c == 258) flushReq = 1'b0;
            if (c == 261) invReq = 1'b0;
            @(negedge clk);
        end
    endtask

    // Invalidate with an empty way mask: ack without any memory access.
    task automatic test_inv_zero_way();
        logic [21:0] exp;
        @(negedge clk);
        invReq = 1'b1;
        invIdx = 8'hC4;
        invWay = 4'b0000;
        for (int c = 0; c <= 3; c++) begin
            #1;
            exp = expVec(1'b0, c == 1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            checkCount++;
            if (obs !== exp) begin
                errorCount++;
                $display("[TB] FAIL inv_zero_way cycle %0d: got %h expected %h", c, obs, exp);
            end
            if (c == 1) invReq = 1'b0;
            @(negedge clk);
        end
    endtask

    // Reset while the flush is writing set 100: abandoned, no ack afterwards.
    task automatic test_reset_mid_flush();
        @(negedge clk);
        memGnt   = 1'b1;
        wbEmpty  = 1'b1;
        flushReq = 1'b1;
        for (int c = 0; c < 102; c++) @(negedge clk);
        #1;
        checkCount++;
        if (obs !== expVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 8'd100)) begin
            errorCount++;
            $display("[TB] FAIL mid_flush_idx100: got %h expected %h", obs,
                     expVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 8'd100));
        end
        rst      = 1'b1;
        flushReq = 1'b0;
        #1;
        checkCount++;
        if (obs !== 22'h0) begin
            errorCount++;
            $display("[TB] FAIL mid_flush_reset: got %h expected %h", obs, 22'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkCount++;
            if (obs !== 22'h0) begin
                errorCount++;
                $display("[TB] FAIL post_reset_idle cycle %0d: got %h expected %h", c, obs, 22'h0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        flushReq = 1'b0;
        invReq   = 1'b0;
        invIdx   = 8'h00;
        invWay   = 4'h0;
        wbEmpty  = 1'b1;
        memGnt   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_flush(0);
        test_flush(10);
        test_random_grant();
        test_invalidate();
        test_flush_and_inv();
        test_inv_zero_way();
        test_reset_mid_flush();
        test_flush(0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
